mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Consumer end of the EX/MEM pipeline register in the LEGv8 pipeline.
- Takes the registered EX/MEM control and data, runs loads and stores against a multi-cycle data memory over a req/ack handshake, and resolves branches.
- Stalls upstream while an access is outstanding.
- Drives the MEM/WB register contents toward writeback.

Parameters:
- TIMEOUT_CYCLES, 16, maximum ACCESS-state cycles without mem_ack before the access is abandoned (range 1..255).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- RegWrite_In, MemtoReg_In, Branch_In, MemRead_In, MemWrite_In, Zero_In  in  1 each  EX/MEM control outputs
- ADD_result_In  in  64  branch target
- ALU_result_In  in  64  memory address / ALU value
- rd_data_2_In  in  64  store data
- RegisterRd_In  in  5  destination register
- mem_req  out  1  memory request, registered
- mem_we  out  1  1=store, 0=load
- mem_addr  out  64  access address
- mem_wdata  out  64  store data
- mem_rdata  in  64  load data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse
- stall  out  1  freeze PC, IF/ID, ID/EX and EX/MEM
- PCSrc  out  1  take branch
- branch_target  out  64  equals ADD_result_In
- RegWrite_Out, MemtoReg_Out  out  1 each  MEM/WB control
- ALU_result_Out  out  64  MEM/WB ALU value
- Read_data_Out  out  64  MEM/WB load data
- RegisterRd_Out  out  5  MEM/WB destination
- mem_fault  out  1  sticky error: misalignment or timeout

Behaviour:
- Reset: state=IDLE, timeout counter=0. mem_req, mem_we, mem_fault and every MEM/WB output are 0. mem_addr and mem_wdata are 0.
- Reset is honoured in any state. Reset during ACCESS drops mem_req at that edge and abandons the transaction. A late mem_ack is then ignored.
- memop = MemRead_In | MemWrite_In. If both are set, the access is a store (mem_we=1).
- misaligned = memop & (ALU_result_In[2:0] != 0).
- stall (combinational):
  - IDLE: memop & ~misaligned.
  - ACCESS: ~mem_ack & (count != TIMEOUT_CYCLES-1).
  - stall is low in the ack cycle so upstream advances on the same edge that loads MEM/WB.
- PCSrc = Branch_In & Zero_In & ~stall (combinational). branch_target = ADD_result_In.
- IDLE, no memop: next edge loads MEM/WB from the inputs and sets Read_data_Out=0. Latency 1.
- IDLE, misaligned: no request is issued. Next edge sets mem_fault=1 and writes a bubble (RegWrite_Out=0, MemtoReg_Out=0). No stall.
- IDLE, aligned memop:
  - Next edge latches RegWrite, MemtoReg, RegisterRd and ALU_result internally.
  - Drives mem_req=1, mem_we, mem_addr=ALU_result_In, mem_wdata=rd_data_2_In.
  - Writes a bubble to MEM/WB, clears count, goes to ACCESS.
- ACCESS: mem_req, mem_we, mem_addr and mem_wdata are held stable. Each cycle without ack: count+1, MEM/WB gets a bubble.
- ACCESS, mem_ack=1:
  - Next edge: mem_req=0.
  - MEM/WB loaded from the latched control and ALU value.
  - Read_data_Out = mem_rdata for a load, 0 for a store (store forces RegWrite_Out to the latched value, normally 0).
  - Goes to IDLE.
- ACCESS, no ack and count==TIMEOUT_CYCLES-1: next edge sets mem_req=0, mem_fault=1, writes a bubble, goes to IDLE. The instruction is dropped.
- Ack and timeout in the same cycle: ack wins.
- mem_ack in IDLE is ignored.
- mem_fault clears only on reset.
- Back-to-back memops: the new access starts the cycle after IDLE is re-entered. Minimum cost is 2 cycles per access when ack comes on the first ACCESS cycle.

Test Plan:
- Reset held 2 cycles mid-ACCESS, then mem_ack=1 → mem_req=0, state IDLE, all outputs 0, mem_fault=0, late ack ignored.
- ALU op (RegWrite_In=1, ALU_result_In=0x1234, RegisterRd_In=5, no memop) → one edge later RegWrite_Out=1, ALU_result_Out=0x1234, RegisterRd_Out=5, stall never asserted.
- Load at addr 0x40, Rd=3, ack 3 cycles after mem_req with mem_rdata=0xDEADBEEF → stall high 4 cycles, mem_addr=0x40 stable, then Read_data_Out=0xDEADBEEF, MemtoReg_Out=1, RegisterRd_Out=3, bubbles before.
- Store, rd_data_2_In=0xA5A5, addr 0x08, ack on first ACCESS cycle → mem_we=1, mem_wdata=0xA5A5, stall high 1 cycle, RegWrite_Out=0.
- Load at addr 0x43 → no mem_req, mem_fault=1 next edge, RegWrite_Out=0; with TIMEOUT_CYCLES=4 and no ack on a load at 0x80 → mem_req drops after 4 ACCESS cycles, mem_fault=1, stall low.
- Branch_In=1, Zero_In=1, ADD_result_In=0x200, no memop → PCSrc=1, branch_target=0x200 same cycle; Zero_In=0 → PCSrc=0.

Source files
------------

// File: rtl/mem_access_stage_if.sv
// ---------------------------------------------------------------------------
// mem_access_stage_if
// Data-memory request/ack bus between the MEM stage and a multi-cycle memory.
//   mem_req   : request, held high for the whole access
//   mem_we    : 1 = store, 0 = load
//   mem_addr  : access address (64)
//   mem_wdata : store data (64)
//   mem_rdata : load data, valid while mem_ack is high (64)
//   mem_ack   : one-cycle completion pulse
// master = pipeline stage, slave = memory.
// ---------------------------------------------------------------------------
interface mem_access_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
// MEM stage of the LEGv8 pipeline. Consumes the EX/MEM register, runs loads
// and stores against a multi-cycle data memory, resolves branches and drives
// the MEM/WB register.
//   clk, reset           : clock, synchronous active-high reset
//   *_In                 : EX/MEM control and data
//   mem                  : data-memory request/ack bus (master side)
//   stall                : freeze PC, IF/ID, ID/EX and EX/MEM
//   PCSrc, branch_target : branch resolution
//   *_Out                : MEM/WB register contents
//   mem_fault            : sticky misalignment / timeout flag
// ---------------------------------------------------------------------------
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite_In,
    input  logic        MemtoReg_In,
    input  logic        Branch_In,
    input  logic        MemRead_In,
    input  logic        MemWrite_In,
    input  logic        Zero_In,
    input  logic [63:0] ADD_result_In,
    input  logic [63:0] ALU_result_In,
    input  logic [63:0] rd_data_2_In,
    input  logic [4:0]  RegisterRd_In,
    mem_access_stage_if.master mem,
    output logic        stall,
    output logic        PCSrc,
    output logic [63:0] branch_target,
    output logic        RegWrite_Out,
    output logic        MemtoReg_Out,
    output logic [63:0] ALU_result_Out,
    output logic [63:0] Read_data_Out,
    output logic [4:0]  RegisterRd_Out,
    output logic        mem_fault
);

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic {S_IDLE, S_ACCESS} state_t;

    // MEM/WB register contents; all-zero is a bubble
    typedef struct packed {
        logic        reg_write;
        logic        memto_reg;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [63:0] rdata;
    } wb_t;

    // writeback control captured when an access is issued
    typedef struct packed {
        logic        reg_write;
        logic        memto_reg;
        logic [4:0]  rd;
        logic [63:0] alu;
    } lat_t;

    state_t      r_state;
    logic [7:0]  r_count;
    logic        r_mem_req;
    logic        r_mem_we;
    logic [63:0] r_mem_addr;
    logic [63:0] r_mem_wdata;
    logic        r_fault;
    wb_t         r_wb;
    lat_t        r_lat;

    logic        w_memop;
    logic        w_misaligned;
    logic        w_stall;

    always_comb begin
        w_memop      = MemRead_In | MemWrite_In;
        w_misaligned = w_memop & (ALU_result_In[2:0] != 3'd0);
        w_stall      = 1'b0;
        case (r_state)
            S_IDLE:   w_stall = w_memop & ~w_misaligned;
            // low in the ack cycle (and the final timeout cycle) so upstream
            // advances on the same edge that loads MEM/WB
            S_ACCESS: w_stall = ~mem.mem_ack & (r_count != LP_LAST);
            default:  w_stall = 1'b0;
        endcase
    end

    assign stall         = w_stall;
    assign PCSrc         = Branch_In & Zero_In & ~w_stall;
    assign branch_target = ADD_result_In;

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;

    assign RegWrite_Out   = r_wb.reg_write;
    assign MemtoReg_Out   = r_wb.memto_reg;
    assign RegisterRd_Out = r_wb.rd;
    assign ALU_result_Out = r_wb.alu;
    assign Read_data_Out  = r_wb.rdata;
    assign mem_fault      = r_fault;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_fault     <= 1'b0;
            r_wb        <= '0;
            r_lat       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!w_memop) begin
                        r_wb <= '{reg_write: RegWrite_In, memto_reg: MemtoReg_In,
                                  rd: RegisterRd_In, alu: ALU_result_In, rdata: 64'd0};
                    end else if (w_misaligned) begin
                        // never reaches memory; instruction becomes a bubble
                        r_wb    <= '0;
                        r_fault <= 1'b1;
                    end else begin
                        r_lat <= '{reg_write: RegWrite_In, memto_reg: MemtoReg_In,
                                   rd: RegisterRd_In, alu: ALU_result_In};
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= MemWrite_In;   // store wins if both set
                        r_mem_addr  <= ALU_result_In;
                        r_mem_wdata <= rd_data_2_In;
                        r_wb        <= '0;
                        r_count     <= '0;
                        r_state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    // ack is checked first so it wins over a coincident timeout
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_wb <= '{reg_write: r_lat.reg_write, memto_reg: r_lat.memto_reg,
                                  rd: r_lat.rd, alu: r_lat.alu,
                                  rdata: r_mem_we ? 64'd0 : mem.mem_rdata};
                        r_state   <= S_IDLE;
                    end else if (r_count == LP_LAST) begin
                        r_mem_req <= 1'b0;
                        r_fault   <= 1'b1;
                        r_wb      <= '0;
                        r_state   <= S_IDLE;
                    end else begin
                        r_count <= r_count + 8'd1;
                        r_wb    <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic        rw;
        logic        m2r;
        logic [63:0] alu;
        logic [63:0] rdata;
        logic [4:0]  rd;
    } wb_t;

    typedef struct {
        logic        rw, m2r, br, mr, mw, zero;
        logic [63:0] add, alu, rd2;
        logic [4:0]  rd;
        logic        e_stall, e_pcsrc, e_fault;
        wb_t         e_wb;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite_In, MemtoReg_In, Branch_In, MemRead_In, MemWrite_In, Zero_In;
    logic [63:0] ADD_result_In, ALU_result_In, rd_data_2_In;
    logic [4:0]  RegisterRd_In;
    logic        stall, PCSrc, RegWrite_Out, MemtoReg_Out, mem_fault;
    logic [63:0] branch_target, ALU_result_Out, Read_data_Out;
    logic [4:0]  RegisterRd_Out;

    mem_access_stage_if mif();

    mem_access_stage #(.TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .RegWrite_In(RegWrite_In), .MemtoReg_In(MemtoReg_In), .Branch_In(Branch_In),
        .MemRead_In(MemRead_In), .MemWrite_In(MemWrite_In), .Zero_In(Zero_In),
        .ADD_result_In(ADD_result_In), .ALU_result_In(ALU_result_In),
        .rd_data_2_In(rd_data_2_In), .RegisterRd_In(RegisterRd_In),
        .mem(mif),
        .stall(stall), .PCSrc(PCSrc), .branch_target(branch_target),
        .RegWrite_Out(RegWrite_Out), .MemtoReg_Out(MemtoReg_Out),
        .ALU_result_Out(ALU_result_Out), .Read_data_Out(Read_data_Out),
        .RegisterRd_Out(RegisterRd_Out), .mem_fault(mem_fault)
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_err    = 0;
    wb_t sb[$];
    wb_t BUB = '{rw: 1'b0, m2r: 1'b0, alu: 64'd0, rdata: 64'd0, rd: 5'd0};
    vec_t tbl[6];

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rw, m2r, br, mr, mw, z,
                                input logic [63:0] add, alu, rd2, input logic [4:0] rd);
        vec_t v;
        v.rw = rw; v.m2r = m2r; v.br = br; v.mr = mr; v.mw = mw; v.zero = z;
        v.add = add; v.alu = alu; v.rd2 = rd2; v.rd = rd;
        v.e_stall = 1'b0; v.e_pcsrc = 1'b0; v.e_fault = 1'b0; v.e_wb = '{1'b0, 1'b0, 64'd0, 64'd0, 5'd0};
        return v;
    endfunction

    task automatic drive(input vec_t v);
        RegWrite_In = v.rw; MemtoReg_In = v.m2r; Branch_In = v.br;
        MemRead_In = v.mr; MemWrite_In = v.mw; Zero_In = v.zero;
        ADD_result_In = v.add; ALU_result_In = v.alu;
        rd_data_2_In = v.rd2; RegisterRd_In = v.rd;
    endtask

    // Every edge loads MEM/WB: queue what it must hold, then compare after the edge.
    task automatic tick_exp(input wb_t e);
        wb_t x;
        sb.push_back(e);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk1 ("RegWrite_Out",   RegWrite_Out,   x.rw);
        chk1 ("MemtoReg_Out",   MemtoReg_Out,   x.m2r);
        chk64("ALU_result_Out", ALU_result_Out, x.alu);
        chk64("Read_data_Out",  Read_data_Out,  x.rdata);
        chk64("RegisterRd_Out", 64'(RegisterRd_Out), 64'(x.rd));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // single-cycle cases
        tbl[0] = mk(1,0,0,0,0,0, 64'h0,   64'h1234, 64'h0, 5'd5);
        tbl[0].e_wb = '{1'b1, 1'b0, 64'h1234, 64'h0, 5'd5};
        tbl[1] = mk(0,0,1,0,0,1, 64'h200, 64'h0, 64'h0, 5'd0);
        tbl[1].e_pcsrc = 1'b1;
        tbl[2] = mk(0,0,1,0,0,0, 64'h200, 64'h0, 64'h0, 5'd0);
        tbl[3] = mk(1,1,0,0,0,0, 64'h8, 64'hFFFF_0000_0000_0007, 64'h55, 5'd31);
        tbl[3].e_wb = '{1'b1, 1'b1, 64'hFFFF_0000_0000_0007, 64'h0, 5'd31};
        tbl[4] = mk(1,1,0,1,0,0, 64'h0, 64'h43, 64'h0, 5'd7);
        tbl[4].e_fault = 1'b1;
        tbl[5] = mk(0,0,1,1,1,1, 64'h180, 64'h44, 64'h9, 5'd1);
        tbl[5].e_pcsrc = 1'b1; tbl[5].e_fault = 1'b1;

        reset = 1'b1;
        mif.mem_ack = 1'b0;
        mif.mem_rdata = 64'd0;
        drive(mk(0,0,0,0,0,0, 0,0,0,0));
        tick_exp(BUB);
        tick_exp(BUB);
        chk1 ("rst mem_req",   mif.mem_req,   1'b0);
        chk1 ("rst mem_we",    mif.mem_we,    1'b0);
        chk64("rst mem_addr",  mif.mem_addr,  64'd0);
        chk64("rst mem_wdata", mif.mem_wdata, 64'd0);
        chk1 ("rst mem_fault", mem_fault,     1'b0);
        reset = 1'b0;

        for (int i = 0; i < 6; i++) begin
            drive(tbl[i]);
            #1;
            chk1 ("tbl stall",  stall, tbl[i].e_stall);
            chk1 ("tbl PCSrc",  PCSrc, tbl[i].e_pcsrc);
            chk64("tbl branch_target", branch_target, tbl[i].add);
            tick_exp(tbl[i].e_wb);
            chk1 ("tbl mem_fault", mem_fault, tbl[i].e_fault);
            chk1 ("tbl mem_req",   mif.mem_req, 1'b0);
        end

        // clear the sticky fault
        reset = 1'b1;
        drive(mk(0,0,0,0,0,0, 0,0,0,0));
        tick_exp(BUB);
        reset = 1'b0;
        chk1("fault cleared", mem_fault, 1'b0);

        // load at 0x40; ack arrives on the last allowed ACCESS cycle
        drive(mk(1,1,1,1,0,1, 64'h300, 64'h40, 64'h0, 5'd3));
        #1;
        chk1("ld stall idle", stall, 1'b1);
        chk1("ld PCSrc idle", PCSrc, 1'b0);
        chk1("ld req idle",   mif.mem_req, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick_exp(BUB);
            chk1 ("ld req",   mif.mem_req, 1'b1);
            chk1 ("ld we",    mif.mem_we,  1'b0);
            chk64("ld addr",  mif.mem_addr, 64'h40);
            chk1 ("ld stall", stall, 1'b1);
            chk1 ("ld PCSrc", PCSrc, 1'b0);
        end
        tick_exp(BUB);
        chk64("ld addr last", mif.mem_addr, 64'h40);
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 64'hDEADBEEF;
        drive(mk(1,0,0,0,0,0, 0, 64'h99, 0, 5'd9));
        #1;
        chk1("ld stall ack", stall, 1'b0);
        tick_exp('{1'b1, 1'b1, 64'h40, 64'hDEADBEEF, 5'd3});
        mif.mem_ack = 1'b0;
        chk1("ld req done",   mif.mem_req, 1'b0);
        chk1("ld fault none", mem_fault,   1'b0);
        tick_exp('{1'b1, 1'b0, 64'h99, 64'h0, 5'd9});

        // store, ack on first ACCESS cycle
        drive(mk(0,0,0,0,1,0, 0, 64'h08, 64'hA5A5, 5'd4));
        #1;
        chk1("st stall idle", stall, 1'b1);
        tick_exp(BUB);
        chk1 ("st req",   mif.mem_req,   1'b1);
        chk1 ("st we",    mif.mem_we,    1'b1);
        chk64("st wdata", mif.mem_wdata, 64'hA5A5);
        chk64("st addr",  mif.mem_addr,  64'h08);
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 64'h1111;
        drive(mk(0,0,0,0,0,0, 0,0,0,0));
        #1;
        chk1("st stall ack", stall, 1'b0);
        tick_exp('{1'b0, 1'b0, 64'h08, 64'h0, 5'd4});
        mif.mem_ack = 1'b0;
        chk1("st req done", mif.mem_req, 1'b0);

        // load at 0x80 never acked: timeout after TB_TIMEOUT ACCESS cycles
        drive(mk(1,1,0,1,0,0, 0, 64'h80, 0, 5'd6));
        #1;
        chk1("to stall idle", stall, 1'b1);
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            tick_exp(BUB);
            chk1("to req",   mif.mem_req, 1'b1);
            chk1("to stall", stall, k < TB_TIMEOUT - 1);
            chk1("to fault", mem_fault, 1'b0);
        end
        drive(mk(0,0,0,0,0,0, 0,0,0,0));
        tick_exp(BUB);
        chk1("to req drop", mif.mem_req, 1'b0);
        chk1("to fault",    mem_fault,   1'b1);
        chk1("to stall",    stall,       1'b0);

        // reset held 2 cycles mid-ACCESS, then a late ack
        drive(mk(1,1,0,1,0,0, 0, 64'h10, 0, 5'd2));
        tick_exp(BUB);
        chk1("rm req", mif.mem_req, 1'b1);
        reset = 1'b1;
        tick_exp(BUB);
        chk1 ("rm req drop", mif.mem_req,  1'b0);
        chk64("rm addr",     mif.mem_addr, 64'd0);
        chk1 ("rm fault",    mem_fault,    1'b0);
        tick_exp(BUB);
        drive(mk(0,0,0,0,0,0, 0,0,0,0));
        reset = 1'b0;
        mif.mem_ack = 1'b1;
        mif.mem_rdata = 64'hCAFE;
        #1;
        chk1("rm stall", stall, 1'b0);
        tick_exp(BUB);
        mif.mem_ack = 1'b0;
        chk1("rm late req",   mif.mem_req, 1'b0);
        chk1("rm late fault", mem_fault,   1'b0);
        chk1("rm late we",    mif.mem_we,  1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
